// File: rtl/qr_cordic_pkg.sv
// Shared constants, FSM states and fixed-point helpers for the CORDIC Givens engine.
package qr_cordic_pkg;

    localparam logic MODE_VECTOR = 1'b0;
    localparam logic MODE_ROTATE = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StIter,
        StComp,
        StDone
    } state_t;

    // CORDIC gain compensation 0.6072529350 scaled by 2^frac, rounded to nearest
    function automatic longint cordic_gain(input int unsigned frac);
        longint num;
        num = 64'sd607252935 <<< frac;
        return (num + 64'sd500000000) / 64'sd1000000000;
    endfunction

    // Clip a value into the signed range of a width-bit two's-complement word
    function automatic longint sat_trunc(input longint val, input int unsigned width);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/qr_cordic_gain.sv
// Gain compensation: multiply by K, round half away from zero, drop guard bits, saturate.
module qr_cordic_gain
    import qr_cordic_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 13,
    parameter int unsigned FRAC        = 8,
    parameter int unsigned GUARD       = 3,
    parameter int unsigned W           = DATA_LENGTH + GUARD + 2
) (
    input  logic signed [W-1:0]           val,
    output logic signed [DATA_LENGTH-1:0] res,
    output logic                          sat
);

    // K carries FRAC+GUARD fraction bits; the operand carries FRAC+GUARD too
    localparam int unsigned SHIFT = FRAC + 2 * GUARD;
    localparam longint      K     = cordic_gain(FRAC + GUARD);

    // Scale, round symmetric about zero, then clip to the output range
    always_comb begin
        longint prod;
        longint mag;
        longint rnd;
        longint full;
        longint clip;
        prod = longint'(val) * K;
        mag  = (prod < 0) ? -prod : prod;
        rnd  = (mag + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        full = (prod < 0) ? -rnd : rnd;
        clip = sat_trunc(full, DATA_LENGTH);
        res  = DATA_LENGTH'(clip);
        sat  = (clip != full);
    end

endmodule

// File: rtl/qr_givens_cordic.sv
// Iterative CORDIC Givens-rotation processing element (VECTOR / ROTATE modes).
module qr_givens_cordic
    import qr_cordic_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 13,
    parameter int unsigned FRAC        = 8,
    parameter int unsigned ITER        = 12,
    parameter int unsigned GUARD       = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_mode,
    input  logic signed [DATA_LENGTH-1:0] in_x,
    input  logic signed [DATA_LENGTH-1:0] in_y,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_LENGTH-1:0] out_x,
    output logic signed [DATA_LENGTH-1:0] out_y,
    output logic                          out_sat,
    output logic                          out_err
);

    localparam int unsigned W  = DATA_LENGTH + GUARD + 2;
    localparam int unsigned CW = $clog2(ITER);

    state_t              state;
    logic                mode_q;
    logic                err_q;
    logic signed [W-1:0] x_q;
    logic signed [W-1:0] y_q;
    logic [CW-1:0]       cnt;
    logic [ITER-1:0]     dir_bits;
    logic [ITER-1:0]     dir_work;
    logic                flip;
    logic                flip_work;
    logic                dirs_valid;

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic signed [W-1:0] x_nx;
    logic signed [W-1:0] y_nx;
    logic                d_neg;
    logic [ITER-1:0]     dir_nx;

    logic signed [DATA_LENGTH-1:0] gain_x;
    logic signed [DATA_LENGTH-1:0] gain_y;
    logic                          sat_x;
    logic                          sat_y;

    // One micro-rotation; d_neg means d = -1 (clockwise)
    always_comb begin
        x_sh   = x_q >>> cnt;
        y_sh   = y_q >>> cnt;
        d_neg  = (mode_q == MODE_VECTOR) ? ~y_q[W-1] : dir_bits[cnt];
        dir_nx = dir_work;
        dir_nx[cnt] = d_neg;
        if (d_neg) begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
        end else begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
        end
    end

    qr_cordic_gain #(
        .DATA_LENGTH(DATA_LENGTH),
        .FRAC       (FRAC),
        .GUARD      (GUARD),
        .W          (W)
    ) u_gain_x (
        .val(x_q),
        .res(gain_x),
        .sat(sat_x)
    );

    qr_cordic_gain #(
        .DATA_LENGTH(DATA_LENGTH),
        .FRAC       (FRAC),
        .GUARD      (GUARD),
        .W          (W)
    ) u_gain_y (
        .val(y_q),
        .res(gain_y),
        .sat(sat_y)
    );

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            mode_q     <= MODE_VECTOR;
            err_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            cnt        <= '0;
            dir_bits   <= '0;
            dir_work   <= '0;
            flip       <= 1'b0;
            flip_work  <= 1'b0;
            dirs_valid <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_sat    <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        mode_q   <= in_mode;
                        x_q      <= {{2{in_x[DATA_LENGTH-1]}}, in_x, {GUARD{1'b0}}};
                        y_q      <= {{2{in_y[DATA_LENGTH-1]}}, in_y, {GUARD{1'b0}}};
                        err_q    <= (in_mode == MODE_ROTATE) && !dirs_valid;
                        out_err  <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= StPre;
                    end
                end
                StPre: begin
                    // Fold left half-plane into the right so CORDIC can converge
                    if (mode_q == MODE_VECTOR) begin
                        flip_work <= x_q[W-1];
                        if (x_q[W-1]) begin
                            x_q <= -x_q;
                            y_q <= -y_q;
                        end
                    end else if (!err_q && flip) begin
                        x_q <= -x_q;
                        y_q <= -y_q;
                    end
                    cnt   <= '0;
                    state <= StIter;
                end
                StIter: begin
                    if (!err_q) begin
                        x_q <= x_nx;
                        y_q <= y_nx;
                    end
                    dir_work <= dir_nx;
                    if (cnt == CW'(ITER - 1)) begin
                        state <= StComp;
                        // Sequence becomes visible to ROTATE only once complete
                        if (mode_q == MODE_VECTOR) begin
                            dir_bits   <= dir_nx;
                            flip       <= flip_work;
                            dirs_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StComp: begin
                    if (err_q) begin
                        out_x   <= x_q[GUARD +: DATA_LENGTH];
                        out_y   <= y_q[GUARD +: DATA_LENGTH];
                        out_sat <= 1'b0;
                    end else begin
                        out_x   <= gain_x;
                        out_y   <= gain_y;
                        out_sat <= sat_x | sat_y;
                    end
                    out_err   <= err_q;
                    out_valid <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
